// File: rtl/vm_pkg.sv
// vm_pkg: shared definitions for the vector mask register file and its
// write-side feeder.
//   VM_NREGS       number of mask registers
//   VM_AW / VM_DW  mask register address / data widths
//   vm_wb_entry_t  one queued write: target register plus mask data
package vm_pkg;

  localparam int VM_NREGS = 8;
  localparam int VM_AW    = 3;
  localparam int VM_DW    = 128;

  typedef struct packed {
    logic [VM_AW-1:0] a;
    logic [VM_DW-1:0] d;
  } vm_wb_entry_t;

endpackage

// File: rtl/vm_wbq_ram.sv
// vm_wbq_ram: DEPTH x vm_wb_entry_t storage for the writeback queue.
// Ports:
//   clk              core clock
//   we0/wp0/wd0      write port 0 (enable, slot index, entry)
//   we1/wp1/wd1      write port 1 (enable, slot index, entry)
//   rp0/rd0          async read port 0 (oldest entry)
//   rp1/rd1          async read port 1 (next-oldest entry)
// The two write slots are always distinct when both are enabled, so there
// is no write-write conflict to resolve. Storage has no reset: validity is
// tracked entirely by the pointers and count in the top level.
module vm_wbq_ram
  import vm_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       we0,
  input  logic [$clog2(DEPTH)-1:0]   wp0,
  input  vm_wb_entry_t               wd0,
  input  logic                       we1,
  input  logic [$clog2(DEPTH)-1:0]   wp1,
  input  vm_wb_entry_t               wd1,
  input  logic [$clog2(DEPTH)-1:0]   rp0,
  output vm_wb_entry_t               rd0,
  input  logic [$clog2(DEPTH)-1:0]   rp1,
  output vm_wb_entry_t               rd1
);

  vm_wb_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we0) mem[wp0] <= wd0;
    if (we1) mem[wp1] <= wd1;
  end

  assign rd0 = mem[rp0];
  assign rd1 = mem[rp1];

endmodule

// File: rtl/vm_writeback_queue.sv
// vm_writeback_queue: in-order FIFO between the mask-producing functional
// units and the two write ports of the 8 x 128-bit mask register file.
// Ports:
//   clk, rst               core clock, asynchronous active-high reset
//   ev0/ea0/ed0            enqueue slot 0 (older when both slots valid)
//   ev1/ea1/ed1            enqueue slot 1 (younger)
//   enq_rdy                two entries may be enqueued this cycle
//   hold                   suppress dequeue this cycle
//   wr0/wa0/i0             file write port 0 (oldest issued entry)
//   wr1/wa1/i1             file write port 1 (younger issued entry)
//   count                  occupied entries
//   pending                per-register "write still queued" flags
// Optional feature: define VM_WBQ_PENDING_EN to build the per-register
// pending scoreboard; otherwise pending is tied to zero.
module vm_writeback_queue
  import vm_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = VM_AW,
  parameter int DW    = VM_DW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ev0,
  input  logic [AW-1:0]             ea0,
  input  logic [DW-1:0]             ed0,
  input  logic                      ev1,
  input  logic [AW-1:0]             ea1,
  input  logic [DW-1:0]             ed1,
  output logic                      enq_rdy,
  input  logic                      hold,
  output logic                      wr0,
  output logic [AW-1:0]             wa0,
  output logic [DW-1:0]             i0,
  output logic                      wr1,
  output logic [AW-1:0]             wa1,
  output logic [DW-1:0]             i1,
  output logic [$clog2(DEPTH):0]    count,
  output logic [2**AW-1:0]          pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rp, wp;
  logic [1:0]    enq_n, deq_n;
  logic          we_a, we_b;
  vm_wb_entry_t  ent_a, ent_b, rd0, rd1;

  // Ready only depends on registered occupancy, so the producers never see a
  // combinational path through hold or the dequeue decision.
  assign enq_rdy = (count <= CW'(DEPTH - 2));

  // Slot compaction: the first valid slot always lands at wp, so a lone ev1
  // becomes a single entry with no hole in the queue.
  always_comb begin
    we_a    = enq_rdy & (ev0 | ev1);
    we_b    = enq_rdy & ev0 & ev1;
    ent_a.a = ev0 ? ea0 : ea1;
    ent_a.d = ev0 ? ed0 : ed1;
    ent_b.a = ea1;
    ent_b.d = ed1;
    enq_n   = 2'd0;
    if (enq_rdy) enq_n = {1'b0, ev0} + {1'b0, ev1};
    deq_n   = 2'd0;
    if (!hold) deq_n = (count >= CW'(2)) ? 2'd2 : count[1:0];
  end

  vm_wbq_ram #(.DEPTH(DEPTH)) u_ram (
    .clk (clk),
    .we0 (we_a),
    .wp0 (wp),
    .wd0 (ent_a),
    .we1 (we_b),
    .wp1 (wp + PW'(1)),
    .wd1 (ent_b),
    .rp0 (rp),
    .rd0 (rd0),
    .rp1 (rp + PW'(1)),
    .rd1 (rd1)
  );

  // Dequeue reads only entries counted in the registered occupancy, so
  // anything written this cycle cannot issue until the next one. When only
  // one entry issues, port 1 address/data keep their previous values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
      wr0   <= 1'b0;
      wa0   <= '0;
      i0    <= '0;
      wr1   <= 1'b0;
      wa1   <= '0;
      i1    <= '0;
    end else begin
      wp    <= wp + PW'(enq_n);
      rp    <= rp + PW'(deq_n);
      count <= count + CW'(enq_n) - CW'(deq_n);
      wr0   <= (deq_n != 2'd0);
      wr1   <= (deq_n == 2'd2);
      if (deq_n != 2'd0) begin
        wa0 <= rd0.a;
        i0  <= rd0.d;
      end
      if (deq_n == 2'd2) begin
        wa1 <= rd1.a;
        i1  <= rd1.d;
      end
    end
  end

`ifdef VM_WBQ_PENDING_EN
  // One occupancy counter per register; pending reflects the counts after
  // this cycle's enqueues and dequeues have been applied.
  logic [CW-1:0] reg_cnt      [2**AW];
  logic [CW-1:0] reg_cnt_next [2**AW];

  always_comb begin
    for (int r = 0; r < 2**AW; r++) begin
      reg_cnt_next[r] = reg_cnt[r];
      if (we_a && ent_a.a == AW'(r)) reg_cnt_next[r] = reg_cnt_next[r] + CW'(1);
      if (we_b && ent_b.a == AW'(r)) reg_cnt_next[r] = reg_cnt_next[r] + CW'(1);
      if (deq_n != 2'd0 && rd0.a == AW'(r)) reg_cnt_next[r] = reg_cnt_next[r] - CW'(1);
      if (deq_n == 2'd2 && rd1.a == AW'(r)) reg_cnt_next[r] = reg_cnt_next[r] - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 2**AW; r++) reg_cnt[r] <= '0;
      pending <= '0;
    end else begin
      for (int r = 0; r < 2**AW; r++) begin
        reg_cnt[r] <= reg_cnt_next[r];
        pending[r] <= (reg_cnt_next[r] != '0);
      end
    end
  end
`else
  assign pending = '0;
`endif

  // Enqueueing into a nearly full queue drops the entries; flag it in sim.
  a_enq_protocol: assert property (@(posedge clk) disable iff (rst)
    !((ev0 || ev1) && !enq_rdy));

endmodule

// File: tb/tb_vm_writeback_queue.sv
// tb_vm_writeback_queue: scoreboard bench for vm_writeback_queue.
// Accepted enqueues push their expected file writes into a queue in program
// order; an independent monitor pops and compares on every issued write.
// Build with VM_WBQ_PENDING_EN defined to also check the pending flags.
module tb_vm_writeback_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         ev0, ev1, hold;
  logic [2:0]   ea0, ea1;
  logic [127:0] ed0, ed1;
  logic         enq_rdy, wr0, wr1;
  logic [2:0]   wa0, wa1;
  logic [127:0] i0, i1;
  logic [3:0]   count;
  logic [7:0]   pending;

  int tests = 0;
  int fails = 0;
  logic [130:0] exp_q [$];

  always #5 clk = ~clk;

  vm_writeback_queue dut (
    .clk(clk), .rst(rst),
    .ev0(ev0), .ea0(ea0), .ed0(ed0),
    .ev1(ev1), .ea1(ea1), .ed1(ed1),
    .enq_rdy(enq_rdy), .hold(hold),
    .wr0(wr0), .wa0(wa0), .i0(i0),
    .wr1(wr1), .wa1(wa1), .i1(i1),
    .count(count), .pending(pending)
  );

  function automatic logic [127:0] pat(input logic [7:0] s);
    return {16{s}};
  endfunction

  function automatic logic [7:0] expPend(input logic [7:0] p);
`ifdef VM_WBQ_PENDING_EN
    return p;
`else
    return 8'h00 & p;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [130:0] act, input logic [130:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of enqueue/hold inputs and record accepted entries.
  task automatic applyStimulus(input logic v0, input logic [2:0] a0, input logic [7:0] s0,
                               input logic v1, input logic [2:0] a1, input logic [7:0] s1,
                               input logic h);
    ev0 = v0; ea0 = a0; ed0 = pat(s0);
    ev1 = v1; ea1 = a1; ed1 = pat(s1);
    hold = h;
    if (v0) exp_q.push_back({a0, pat(s0)});
    if (v1) exp_q.push_back({a1, pat(s1)});
    @(posedge clk); #1;
    ev0 = 1'b0; ev1 = 1'b0;
  endtask

  task automatic step(input logic h);
    hold = h;
    @(posedge clk); #1;
  endtask

  // Monitor: every issued write must be the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr1 && !wr0) checkOutput("wr1_without_wr0", 131'(wr1), 131'(0));
      if (wr0) begin
        if (exp_q.size() == 0) checkOutput("unexpected_wr0", {wa0, i0}, 131'(0));
        else checkOutput("port0_entry", {wa0, i0}, exp_q.pop_front());
      end
      if (wr1) begin
        if (exp_q.size() == 0) checkOutput("unexpected_wr1", {wa1, i1}, 131'(0));
        else checkOutput("port1_entry", {wa1, i1}, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; hold = 1'b0;
    ev0 = 1'b0; ev1 = 1'b0; ea0 = '0; ea1 = '0; ed0 = '0; ed1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_count", 131'(count), 131'(0));
    checkOutput("reset_enq_rdy", 131'(enq_rdy), 131'(1));
    checkOutput("reset_wr", 131'({wr0, wr1}), 131'(0));
    checkOutput("reset_pending", 131'(pending), 131'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Single entry: visible on port 0 one cycle after it is queued.
    applyStimulus(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("t1_count_q", 131'(count), 131'(1));
    checkOutput("t1_wr0_early", 131'(wr0), 131'(0));
    checkOutput("t1_pending_set", 131'(pending), 131'(expPend(8'h08)));
    step(1'b0);
    @(negedge clk);
    checkOutput("t1_wr", 131'({wr0, wr1}), 131'(2'b10));
    checkOutput("t1_wa0", 131'(wa0), 131'(3));
    checkOutput("t1_count_drained", 131'(count), 131'(0));
    checkOutput("t1_pending_clr", 131'(pending), 131'(0));
    step(1'b0);
    @(negedge clk);
    checkOutput("t1_wr0_idle", 131'(wr0), 131'(0));

    // Fill under hold, check the ready threshold, then drain in order.
    applyStimulus(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b1);
    applyStimulus(1'b1, 3'd3, 8'h33, 1'b1, 3'd4, 8'h44, 1'b1);
    applyStimulus(1'b1, 3'd5, 8'h55, 1'b1, 3'd6, 8'h66, 1'b1);
    @(negedge clk);
    checkOutput("t2_count6", 131'(count), 131'(6));
    checkOutput("t2_rdy_at6", 131'(enq_rdy), 131'(1));
    applyStimulus(1'b1, 3'd7, 8'h77, 1'b1, 3'd0, 8'h88, 1'b1);
    @(negedge clk);
    checkOutput("t2_count8", 131'(count), 131'(8));
    checkOutput("t2_rdy_at8", 131'(enq_rdy), 131'(0));
    checkOutput("t2_pending_full", 131'(pending), 131'(expPend(8'hFF)));
    step(1'b1);
    @(negedge clk);
    checkOutput("t2_hold_wr0", 131'(wr0), 131'(0));
    checkOutput("t2_hold_count", 131'(count), 131'(8));
    for (int k = 0; k < 4; k++) begin
      step(1'b0);
      @(negedge clk);
      checkOutput("t2_drain_wr1", 131'(wr1), 131'(1));
      checkOutput("t2_drain_count", 131'(count), 131'(6 - 2 * k));
    end
    step(1'b0);

    // Same-address pair: both issue, port 1 carries the younger data.
    applyStimulus(1'b1, 3'd2, 8'h5A, 1'b1, 3'd2, 8'hC3, 1'b0);
    step(1'b0);
    @(negedge clk);
    checkOutput("t3_wr", 131'({wr0, wr1}), 131'(2'b11));
    checkOutput("t3_addrs", 131'({wa0, wa1}), 131'({3'd2, 3'd2}));
    checkOutput("t3_i1_final", 131'(i1), 131'(pat(8'hC3)));
    step(1'b0);

    // Compaction of a lone slot-1 entry and an odd final issue cycle.
    applyStimulus(1'b1, 3'd4, 8'h14, 1'b1, 3'd5, 8'h15, 1'b1);
    applyStimulus(1'b1, 3'd6, 8'h16, 1'b0, 3'd0, 8'h00, 1'b1);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h17, 1'b1);
    @(negedge clk);
    checkOutput("t4_compact_count", 131'(count), 131'(4));
    applyStimulus(1'b1, 3'd1, 8'h18, 1'b0, 3'd0, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput("t4_pending", 131'(pending), 131'(expPend(8'hF2)));
    step(1'b0);
    @(negedge clk);
    checkOutput("t4_c1", 131'({wr1, count}), 131'({1'b1, 4'd3}));
    step(1'b0);
    @(negedge clk);
    checkOutput("t4_c2", 131'({wr1, count, wa1}), 131'({1'b1, 4'd1, 3'd7}));
    step(1'b0);
    @(negedge clk);
    checkOutput("t4_odd_wr1", 131'({wr0, wr1}), 131'(2'b10));
    checkOutput("t4_wa1_held", 131'(wa1), 131'(7));
    step(1'b0);

    // Continuous 2-in/2-out streaming across several pointer wraps.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 3'(k), 8'(8'h40 + 2 * k), 1'b1, 3'(k + 3), 8'(8'h41 + 2 * k), 1'b0);
      @(negedge clk);
      checkOutput("t5_count", 131'(count), 131'(2));
      if (k > 0) checkOutput("t5_dual_issue", 131'({wr0, wr1}), 131'(2'b11));
    end
    step(1'b0);
    @(negedge clk);
    checkOutput("t5_final_count", 131'(count), 131'(0));
    step(1'b0);
    checkOutput("scoreboard_empty", 131'(exp_q.size()), 131'(0));

    // Reset mid-drain with 5 entries queued and a write on the ports.
    applyStimulus(1'b1, 3'd0, 8'h90, 1'b1, 3'd1, 8'h91, 1'b1);
    applyStimulus(1'b1, 3'd2, 8'h92, 1'b1, 3'd3, 8'h93, 1'b1);
    applyStimulus(1'b1, 3'd4, 8'h94, 1'b1, 3'd5, 8'h95, 1'b1);
    applyStimulus(1'b1, 3'd6, 8'h96, 1'b0, 3'd0, 8'h00, 1'b0);
    checkOutput("t6_pre_rst", 131'({wr0, count}), 131'({1'b1, 4'd5}));
    rst = 1'b1;
    #1;
    exp_q.delete();
    checkOutput("t6_rst_wr", 131'({wr0, wr1, wa0, wa1}), 131'(0));
    checkOutput("t6_rst_data", 131'(i0 | i1), 131'(0));
    checkOutput("t6_rst_state", 131'({enq_rdy, count, pending}), 131'({1'b1, 4'd0, 8'd0}));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0);
      @(negedge clk);
      checkOutput("t6_quiet", 131'({wr0, wr1, count}), 131'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
